mio_arbiter: RTL
================

# mio_arbiter

Two-requester arbiter that shares the single-port MIO memory between the multi-cycle CPU and the snake display engine, which fetches video/board data. It sits between the CPU's MIO port and the memory block. It serialises accesses, drives the memory address/write strobe, and returns a one-cycle ready pulse to the winning requester. It generates the CPU's `MIO_ready`, so the CPU stalls in instruction fetch while the display engine owns the memory.

## Interface
- `MEM_LAT`, default 2: memory read latency in cycles from address valid to `mem_rdata` valid. Legal range 1..7.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request (`CPU_MIO & (MemRead|MemWrite)`); held until `cpu_ready`.
- `cpu_we`  in  1  CPU write when 1, read when 0.
- `cpu_addr`  in  32  CPU byte address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_rdata`  out  32  registered CPU read data.
- `cpu_ready`  out  1  one-cycle completion pulse; connects to `MIO_ready`.
- `dsp_req`  in  1  display read request; held until `dsp_ready`.
- `dsp_addr`  in  32  display byte address; the display port is read-only.
- `dsp_rdata`  out  32  registered display read data.
- `dsp_ready`  out  1  one-cycle completion pulse.
- `mem_addr`  out  32  memory address.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data.
- `grant`  out  2  current owner: 00 none, 01 CPU, 10 display; 11 never occurs.
- `busy`  out  1  1 whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - `grant`=00, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - If any request is high, pick a winner and latch its addr, we and wdata into internal registers.
  - Load the latency counter `cnt` with 0 and go to ACCESS.
- Tie-break (both requests high in the same IDLE cycle) follows the Configuration section. A single requester always wins.
- ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - `mem_we` = latched we during the first ACCESS cycle only (`cnt`==0). It is 0 for every other ACCESS cycle.
  - `cnt` increments each cycle.
  - In the cycle where `cnt`==MEM_LAT-1, capture `mem_rdata` into the owner's rdata register and go to DONE. For writes the capture still happens; the captured value is don't-care to the requester.
- DONE:
  - Owner's ready = 1 for exactly this cycle.
  - `mem_addr` is still driven from the latched address; `mem_we`=0.
  - Update `last_owner`, then go to IDLE.
- Requests are not re-sampled during ACCESS or DONE. A requester that drops its request mid-access still receives its ready pulse.
- A requester that keeps its request high after ready is treated as a new request in the following IDLE cycle.
- The non-owner's rdata register holds its previous value.

## Timing
- Reset (asynchronous assert on `reset_n`=0):
  - State = IDLE.
  - All outputs 0: `cpu_rdata`, `dsp_rdata`, ready pulses, `grant`, `busy`, and all `mem_*` outputs.
  - `cnt`=0, `last_owner`=display.
  - Reset asserted mid-ACCESS aborts the access with no ready pulse; a write strobe in flight is dropped.
- Deassertion is sampled on the next rising edge.
- Latency (IDLE cycle with request high = cycle 0):
  - ACCESS occupies cycles 1..MEM_LAT.
  - DONE/ready occurs in cycle MEM_LAT+1.
  - With MEM_LAT=2, ready is high in cycle 3.
- Back-to-back: with a pending request, the next grant is in the IDLE cycle after DONE, so the access period is MEM_LAT+2 cycles.
- `grant` and `busy` are registered. They are valid from cycle 1 through DONE and return to 0 in IDLE.
- Ready outputs are registered (decoded from state DONE plus owner) and glitch-free.

## Configuration
- `MIO_ARB_RR_EN` defined: round-robin tie-break. The winner is the requester that is not `last_owner`. After reset `last_owner` = display, so the CPU wins the first tie.
- `MIO_ARB_RR_EN` undefined: fixed priority; the display always wins ties, to protect scan-out deadlines. `last_owner` is still maintained but unused.

## Test plan
- Reset: hold `reset_n`=0 with both requests high -> all outputs 0. After release, with MEM_LAT=2, the CPU read of 0x10 completes: `cpu_ready` is high in cycle 3 and `cpu_rdata` = memory word at 0x10.
- CPU write: `cpu_we`=1, `cpu_addr`=0x20, `cpu_wdata`=0xDEADBEEF -> `mem_we` high for exactly 1 cycle with `mem_addr`=0x20. A subsequent CPU read of 0x20 returns 0xDEADBEEF.
- Simultaneous requests for 3 consecutive arbitrations:
  - RR build: grants CPU, display, CPU.
  - Fixed build: grants display, display, display while `dsp_req` stays high; the CPU is served only after `dsp_req` drops.
- Display request arrives during a CPU ACCESS -> it waits. `dsp_ready` occurs 4 cycles after `cpu_ready` (MEM_LAT=2). `cpu_rdata` is unchanged by the display access.
- Request dropped in cycle 1 of ACCESS -> the ready pulse is still issued in cycle 3, then IDLE with `grant`=00.
- `reset_n` pulsed low in cycle 2 of a CPU write with MEM_LAT=3 -> no `cpu_ready`, state IDLE, and the next access proceeds normally.

Source files
------------

// File: rtl/mio_arbiter.sv
// mio_arbiter: serialises CPU and display-engine accesses to the single-port MIO memory.
// Define MIO_ARB_RR_EN for a round-robin tie-break; by default the display wins ties.
module mio_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dsp_req,
  input  logic [31:0] dsp_addr,
  output logic [31:0] dsp_rdata,
  output logic        dsp_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       owner_dsp;
  logic       last_owner_dsp;
  logic       win_dsp;

  always_comb begin
`ifdef MIO_ARB_RR_EN
    win_dsp = dsp_req & (~cpu_req | ~last_owner_dsp);
`else
    win_dsp = dsp_req;
`endif
  end

  // mem_addr/mem_wdata double as the latched request registers for the whole access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      owner_dsp      <= 1'b0;
      last_owner_dsp <= 1'b1;
      cpu_rdata      <= '0;
      dsp_rdata      <= '0;
      cpu_ready      <= 1'b0;
      dsp_ready      <= 1'b0;
      grant          <= '0;
      busy           <= 1'b0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wdata      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req | dsp_req) begin
            state     <= ACCESS;
            cnt       <= '0;
            owner_dsp <= win_dsp;
            grant     <= win_dsp ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            mem_addr  <= win_dsp ? dsp_addr : cpu_addr;
            mem_we    <= ~win_dsp & cpu_we;
            mem_wdata <= win_dsp ? '0 : cpu_wdata;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          cnt    <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
            if (owner_dsp) begin
              dsp_rdata <= mem_rdata;
              dsp_ready <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          cpu_ready      <= 1'b0;
          dsp_ready      <= 1'b0;
          grant          <= '0;
          busy           <= 1'b0;
          mem_addr       <= '0;
          mem_wdata      <= '0;
          last_owner_dsp <= owner_dsp;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_legal: assert property (@(posedge clk) disable iff (!reset_n) grant != 2'b11);
  a_ready_excl:  assert property (@(posedge clk) disable iff (!reset_n) !(cpu_ready && dsp_ready));
  a_last_owner:  assert property (@(posedge clk) disable iff (!reset_n)
                                  (state == DONE) |=> (last_owner_dsp == owner_dsp));

endmodule
